// File: rtl/mem_bus_responder_pkg.sv
// Shared memory-map constants for the bus responder and the memory controller.
// IO space is the 64 KiB window selected by address bits 17:16 == 2'b11.
package mem_bus_responder_pkg;

  localparam logic [17:0] IO_BASE      = 18'h30000;
  localparam logic [17:0] IO_TX_ADDR   = 18'h30000;
  localparam logic [17:0] IO_HALT_ADDR = 18'h30004;

  function automatic logic is_io_space(input logic [1:0] sel);
    return sel == IO_BASE[17:16];
  endfunction

endpackage

// File: rtl/mem_bus_responder_tx_fifo.sv
// tx_fifo: byte FIFO feeding the UART; dout is the combinational head, zero-cycle read.
// Push is accepted when not full or when a pop lands on the same edge; otherwise dropped.
module tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_FULL);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // A full FIFO can still take a byte if the head leaves on the same edge.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Byte RAM plus IO window (UART TX FIFO, halt flag); RAM reads return one cycle later.
// rdy_in low freezes the bus side; io_buffer_full warns two entries before the FIFO fills.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] bus_addr,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_wr,
  output logic [7:0]  bus_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_done,
  output logic        fifo_overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] ALMOST_FULL = CNT_W'(FIFO_DEPTH - 2);

  logic [7:0]        r_ram [2**ADDR_W];
  logic [7:0]        r_rdata;
  logic              r_program_done;
  logic              r_fifo_overflow;

  logic              w_is_io;
  logic [ADDR_W-1:0] w_ram_idx;
  logic              w_ram_we;
  logic              w_push;
  logic              w_halt;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_unused;

  assign w_unused  = ^bus_addr[31:18];
  assign w_is_io   = is_io_space(bus_addr[17:16]);
  assign w_ram_idx = bus_addr[ADDR_W-1:0];
  assign w_ram_we  = rdy_in && bus_wr && !w_is_io && !rst_in;
  assign w_push    = rdy_in && bus_wr && (bus_addr[17:0] == IO_TX_ADDR);
  assign w_halt    = rdy_in && bus_wr && (bus_addr[17:0] == IO_HALT_ADDR);

  always_ff @(posedge clk_in) begin
    if (w_ram_we) r_ram[w_ram_idx] <= bus_wdata;
  end

  // Forwarding the write byte keeps same-cycle read-back write-first.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rdata <= 8'h00;
    end else if (rdy_in) begin
      if (w_is_io)     r_rdata <= 8'h00;
      else if (bus_wr) r_rdata <= bus_wdata;
      else             r_rdata <= r_ram[w_ram_idx];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_program_done  <= 1'b0;
      r_fifo_overflow <= 1'b0;
    end else begin
      if (w_halt) r_program_done <= 1'b1;
      // A full FIFO is never empty, so tx_ready alone decides whether the head leaves.
      if (w_push && w_fifo_full && !tx_ready) r_fifo_overflow <= 1'b1;
    end
  end

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (w_push),
    .din    (bus_wdata),
    .pop    (tx_ready),
    .dout   (tx_data),
    .count  (w_fifo_count),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty)
  );

  assign bus_rdata      = r_rdata;
  assign tx_valid       = !w_fifo_empty;
  assign io_buffer_full = (w_fifo_count >= ALMOST_FULL);
  assign program_done   = r_program_done;
  assign fifo_overflow  = r_fifo_overflow;

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, meaning RAM holds 2^ADDR_W bytes.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning TX FIFO entries; must be a power of two and at least 4.
REQ-003 SHALL have port clk_in  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port rdy_in  input  1  bus-side enable; low freezes the bus side.
REQ-006 SHALL have port bus_addr  input  32  byte address from the controller; only bits 17:0 decoded.
REQ-007 SHALL have port bus_wdata  input  8  write byte from the controller.
REQ-008 SHALL have port bus_wr  input  1  1 = write, 0 = read.
REQ-009 SHALL have port bus_rdata  output  8  read byte returned to the controller.
REQ-010 SHALL have port io_buffer_full  output  1  TX FIFO almost full; controller holds IO writes while high.
REQ-011 SHALL have port tx_data  output  8  byte at the FIFO head.
REQ-012 SHALL have port tx_valid  output  1  FIFO non-empty.
REQ-013 SHALL have port tx_ready  input  1  UART sink accepts tx_data when high with tx_valid.
REQ-014 SHALL have port program_done  output  1  sticky halt flag.
REQ-015 SHALL have port fifo_overflow  output  1  sticky flag: an IO byte was dropped.

Function
REQ-016 SHALL decode bus_addr[17:16]==2'b11 as IO space and all other addresses as RAM, indexed by bus_addr[ADDR_W-1:0].
REQ-017 SHALL give RAM reads one-cycle latency: bus_rdata at edge N+1 equals ram[addr sampled at edge N].
REQ-018 SHALL write bus_wdata to RAM at the edge where bus_wr=1, rdy_in=1 and the address is RAM space.
REQ-019 SHALL, on a same-address write then read on consecutive cycles, return the newly written byte (write-first ordering).
REQ-020 SHALL return 8'h00 on bus_rdata for every IO-space read.
REQ-021 SHALL push bus_wdata into the FIFO on an IO write to 0x30000 with rdy_in=1.
REQ-022 SHALL set program_done on an IO write to 0x30004 with rdy_in=1; IO writes to any other IO address have no effect.
REQ-023 SHALL pop the FIFO head at each edge where tx_valid=1 and tx_ready=1, independent of rdy_in.
REQ-024 SHALL leave the count unchanged on a simultaneous push and pop, and keep the head byte order.
REQ-025 SHALL drop a push when count==FIFO_DEPTH with no simultaneous pop, and set fifo_overflow.
REQ-026 SHALL drive io_buffer_full combinationally high when count >= FIFO_DEPTH-2, giving 2 bytes of slack for writes already in flight.
REQ-027 SHALL wrap read and write pointers modulo FIFO_DEPTH, using a count register of width log2(FIFO_DEPTH)+1.
REQ-028 SHALL, while rdy_in=0, block RAM writes, pushes and program_done updates, and hold bus_rdata.

Reset
REQ-029 SHALL clear bus_rdata, FIFO pointers, count, tx_valid, program_done and fifo_overflow to 0 at a reset edge; io_buffer_full follows as 0.
REQ-030 SHALL discard FIFO contents on reset mid-drain; tx_valid is 0 the cycle after reset.
REQ-031 SHALL NOT initialise or clear RAM contents on reset; preload is by simulation only.
REQ-032 SHALL give reset priority over a concurrent bus write or pop.

Structure
REQ-033 SHALL place IO_BASE=0x30000, IO_TX_ADDR=0x30000 and IO_HALT_ADDR=0x30004 in the shared package used by memctrl.
REQ-034 SHALL implement the FIFO as sub-module tx_fifo, with ports push, din, pop, dout, count, full and empty.
REQ-035 SHALL keep RAM as an inferred single-port array inside mem_bus_responder.

Verification
REQ-036 Write 0xA5 to 0x00010, then read 0x00010 on the next cycle -> bus_rdata=0xA5 one cycle after the read.
REQ-037 Push 0x41,0x42,0x43 to 0x30000 with tx_ready=0, then raise tx_ready -> tx_data=0x41,0x42,0x43 on consecutive cycles, then tx_valid=0.
REQ-038 With tx_ready=0, push 14 bytes -> io_buffer_full rises after the 14th; push 3 more -> the 17th is dropped, fifo_overflow=1, count=16.
REQ-039 At count=5, do push and pop in the same cycle -> count stays 5 and the popped byte is the oldest.
REQ-040 Write to 0x30004 with rdy_in=0 -> program_done stays 0; repeat with rdy_in=1 -> program_done=1 and stays set.
REQ-041 Assert rst_in while the FIFO holds 4 bytes -> next cycle tx_valid=0 and io_buffer_full=0; RAM byte at 0x00010 still reads 0xA5.
